// File: rtl/clk_pkg.sv
// ============================================================================
// Module      : clk_pkg
// Description : Shared constants for the real-time clock and its load-port
//               master: load addresses, field limits and loader FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_pkg;

    localparam logic [1:0] ADDR_SEC = 2'b00;
    localparam logic [1:0] ADDR_MIN = 2'b01;
    localparam logic [1:0] ADDR_HRS = 2'b10;

    localparam int MAX_SEC = 59;
    localparam int MAX_MIN = 59;
    localparam int MAX_HRS = 23;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_HRS = 3'd1,
        ST_GAP1   = 3'd2,
        ST_WR_MIN = 3'd3,
        ST_GAP2   = 3'd4,
        ST_WR_SEC = 3'd5,
        ST_FIN    = 3'd6
    } loader_state_e;

endpackage : clk_pkg

`default_nettype wire

// File: rtl/time_set_loader.sv
// ============================================================================
// Module      : time_set_loader
// Description : Range-checks one time-set request and writes hours, minutes,
//               then seconds onto the real-time clock's load bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_loader
    import clk_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] set_hours,
    input  logic [5:0] set_minutes,
    input  logic [5:0] set_seconds,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       load,
    output logic [1:0] addrs,
    output logic [5:0] data_out
);

    localparam bit         C_NO_GAP   = (GAP_CYCLES == 0);
    localparam logic [3:0] C_GAP_LAST = 4'(GAP_CYCLES - 1);

    loader_state_e state_q;
    logic [3:0]    gap_cnt_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;
    logic          load_q;
    logic [1:0]    addrs_q;
    logic [5:0]    data_q;

    logic          range_err_d;

    assign range_err_d = (set_hours   > 5'(MAX_HRS)) ||
                         (set_minutes > 6'(MAX_MIN)) ||
                         (set_seconds > 6'(MAX_SEC));

    // Hours are driven onto the bus in the cycle after latching, so only
    // minutes and seconds need holding registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= 4'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            load_q    <= 1'b0;
            addrs_q   <= 2'b00;
            data_q    <= 6'd0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            load_q  <= 1'b0;
            addrs_q <= 2'b00;
            data_q  <= 6'd0;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        min_q <= set_minutes;
                        sec_q <= set_seconds;
                        if (range_err_d) begin
                            error_q <= 1'b1;
                        end else begin
                            state_q <= ST_WR_HRS;
                            busy_q  <= 1'b1;
                            load_q  <= 1'b1;
                            addrs_q <= ADDR_HRS;
                            data_q  <= {1'b0, set_hours};
                        end
                    end
                end

                ST_WR_HRS: begin
                    if (C_NO_GAP) begin
                        state_q <= ST_WR_MIN;
                        load_q  <= 1'b1;
                        addrs_q <= ADDR_MIN;
                        data_q  <= min_q;
                    end else begin
                        state_q   <= ST_GAP1;
                        gap_cnt_q <= C_GAP_LAST;
                    end
                end

                ST_GAP1: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= ST_WR_MIN;
                        load_q  <= 1'b1;
                        addrs_q <= ADDR_MIN;
                        data_q  <= min_q;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end

                ST_WR_MIN: begin
                    if (C_NO_GAP) begin
                        state_q <= ST_WR_SEC;
                        load_q  <= 1'b1;
                        addrs_q <= ADDR_SEC;
                        data_q  <= sec_q;
                    end else begin
                        state_q   <= ST_GAP2;
                        gap_cnt_q <= C_GAP_LAST;
                    end
                end

                ST_GAP2: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q <= ST_WR_SEC;
                        load_q  <= 1'b1;
                        addrs_q <= ADDR_SEC;
                        data_q  <= sec_q;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end

                ST_WR_SEC: begin
                    state_q <= ST_FIN;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign load     = load_q;
    assign addrs    = addrs_q;
    assign data_out = data_q;

endmodule : time_set_loader

`default_nettype wire
